// File: rtl/sram_test_pkg.sv
// Shared types and helpers for the SRAM march tester: FSM state encoding,
// default geometry and the data pattern generator used by RTL and bench.
package sram_test_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRmw,
    StVerify,
    StDrain,
    StDone
  } state_e;

  // Callers truncate to the data width, which gives the mod 2**DATA_W wrap.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/sram_tester_check.sv
// Compare stage: registers the expected byte at issue, compares it with the
// SRAM read data one cycle later, counts mismatches and latches the first one.
module sram_tester_check #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [DATA_W-1:0] issue_exp_i,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              mismatch_o,
  output logic [ADDR_W+1:0] err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_got_o
);

  logic              chk_valid_q, chk_valid_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;
  logic [ADDR_W+1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;
  logic              mismatch;

  always_comb begin
    chk_valid_d = issue_valid_i;
    chk_addr_d  = issue_addr_i;
    chk_exp_d   = issue_exp_i;
    mismatch    = chk_valid_q && (mem_dout_i != chk_exp_q);
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_got_d  = fail_got_q;
    if (clear_i) begin
      err_count_d = '0;
      fail_addr_d = '0;
      fail_got_d  = '0;
    end else if (mismatch) begin
      err_count_d = err_count_q + 1'b1;
      if (err_count_q == '0) begin
        fail_addr_d = chk_addr_q;
        fail_got_d  = mem_dout_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chk_valid_q <= 1'b0;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      fail_got_q  <= '0;
    end else begin
      chk_valid_q <= chk_valid_d;
      chk_addr_q  <= chk_addr_d;
      chk_exp_q   <= chk_exp_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign mismatch_o  = mismatch;
  assign err_count_o = err_count_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_got_o  = fail_got_q;

endmodule

// File: rtl/sram_march_tester.sv
// March self-test sequencer for a single-port read-before-write SRAM:
// ascending fill, read-modify-write and verify passes with pass/fail report.
module sram_march_tester
  import sram_test_pkg::*;
#(
  parameter int unsigned          ADDR_W = DefAddrW,
  parameter int unsigned          DATA_W = DefDataW,
  parameter logic [DATA_W-1:0]    SEED   = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_got,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(pattern(32'(SEED), 32'(a)));
  endfunction

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              ce_q, ce_d;
  logic              wre_q, wre_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic [ADDR_W-1:0] ad_inc;
  logic              wrap;
  logic              clear;
  logic              issue_valid;
  logic [DATA_W-1:0] issue_exp;
  logic              mismatch;
  logic [ADDR_W+1:0] err_count_w;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    ce_d        = ce_q;
    wre_d       = wre_q;
    ad_d        = ad_q;
    din_d       = din_q;
    clear       = 1'b0;
    issue_valid = 1'b0;
    issue_exp   = pat(ad_q);
    ad_inc      = ad_q + 1'b1;
    wrap        = (ad_q == LastAddr);
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFill;
          ce_d    = 1'b1;
          wre_d   = 1'b1;
          ad_d    = '0;
          din_d   = pat('0);
          done_d  = 1'b0;
          pass_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      StFill: begin
        ad_d  = ad_inc;
        din_d = pat(ad_inc);
        if (wrap) begin
          state_d = StRmw;
          din_d   = ~pat(ad_inc);
        end
      end
      StRmw: begin
        // Old byte comes back next cycle; it must still hold the fill pattern.
        issue_valid = 1'b1;
        issue_exp   = pat(ad_q);
        ad_d        = ad_inc;
        din_d       = ~pat(ad_inc);
        if (wrap) begin
          state_d = StVerify;
          wre_d   = 1'b0;
          din_d   = '0;
        end
      end
      StVerify: begin
        issue_valid = 1'b1;
        issue_exp   = ~pat(ad_q);
        ad_d        = ad_inc;
        if (wrap) begin
          state_d = StDrain;
          ce_d    = 1'b0;
        end
      end
      StDrain: begin
        // Final verify compare resolves this cycle, so fold it into pass.
        state_d = StDone;
        done_d  = 1'b1;
        pass_d  = (err_count_w == '0) && !mismatch;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StFill) || (state_d == StRmw) || (state_d == StVerify) ||
             (state_d == StDrain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      ad_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      ad_q    <= ad_d;
      din_q   <= din_d;
    end
  end

  sram_tester_check #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_check (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (clear),
    .issue_valid_i(issue_valid),
    .issue_addr_i (ad_q),
    .issue_exp_i  (issue_exp),
    .mem_dout_i   (mem_dout),
    .mismatch_o   (mismatch),
    .err_count_o  (err_count_w),
    .fail_addr_o  (fail_addr),
    .fail_got_o   (fail_got)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_w;
  assign mem_ce    = ce_q;
  assign mem_oce   = 1'b1;
  assign mem_wre   = wre_q;
  assign mem_ad    = ad_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Directed bench: two testers (SEED A5 and FF) each driving a behavioural
// 16x8 read-before-write SRAM with selectable stuck-bit and aliasing faults.
module tb_sram_march_tester;
  import sram_test_pkg::*;

  logic clk = 1'b0;
  logic reset, start, start_ff;
  int   fault;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       busy, done, pass, mem_ce, mem_oce, mem_wre;
  logic [5:0] err_count;
  logic [3:0] fail_addr, mem_ad;
  logic [7:0] fail_got, mem_din, mem_dout;

  logic       busy_ff, done_ff, pass_ff, ce_ff, oce_ff, wre_ff;
  logic [5:0] err_ff;
  logic [3:0] fa_ff, ad_ff;
  logic [7:0] fg_ff, din_ff, dout_ff;

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .SEED(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_got(fail_got),
    .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_ad(mem_ad),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .SEED(8'hFF)) u_dut_ff (
    .clk(clk), .reset(reset), .start(start_ff), .busy(busy_ff), .done(done_ff),
    .pass(pass_ff), .err_count(err_ff), .fail_addr(fa_ff), .fail_got(fg_ff),
    .mem_ce(ce_ff), .mem_oce(oce_ff), .mem_wre(wre_ff), .mem_ad(ad_ff),
    .mem_din(din_ff), .mem_dout(dout_ff)
  );

  // Fault 1: bit 0 of address 5 stuck at 0. Fault 2: address bit 3 ignored.
  logic [7:0] mem   [16];
  logic [7:0] mem_b [16];
  logic [3:0] eff_ad;
  logic [7:0] eff_din;
  assign eff_ad  = (fault == 2) ? {1'b0, mem_ad[2:0]} : mem_ad;
  assign eff_din = (fault == 1 && eff_ad == 4'd5) ? (mem_din & 8'hFE) : mem_din;

  always @(posedge clk) begin
    if (reset) mem_dout <= 8'h00;
    else if (mem_ce) begin
      mem_dout <= mem[eff_ad];
      if (mem_wre) mem[eff_ad] <= eff_din;
    end
  end

  always @(posedge clk) begin
    if (reset) dout_ff <= 8'h00;
    else if (ce_ff) begin
      dout_ff <= mem_b[ad_ff];
      if (wre_ff) mem_b[ad_ff] <= din_ff;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Start is sampled at the edge that closes cycle 0; returns in cycle 1.
  task automatic kick(input bit which);
    if (which) start_ff = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    start_ff = 1'b0;
    cyc      = 1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    start_ff = 1'b0;
    fault    = 0;
    cyc      = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_faddr", fail_addr, 0);
    check("rst_fgot", fail_got, 0);
    check("rst_ce", mem_ce, 0);
    check("rst_wre", mem_wre, 0);
    check("rst_ad", mem_ad, 0);
    check("rst_din", mem_din, 0);
    check("rst_oce", mem_oce, 1);
    @(posedge clk);
    #1;

    // Good memory, with an ignored start pulse at cycle 10
    kick(0);
    check("c1_busy", busy, 1);
    check("c1_ce", mem_ce, 1);
    check("c1_wre", mem_wre, 1);
    check("c1_din", mem_din, 8'hA5);
    goto(4);
    check("fill3_ad", mem_ad, 3);
    check("fill3_din", mem_din, 8'hA8);
    goto(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    goto(17);
    check("rmw0_ad", mem_ad, 0);
    check("rmw0_din", mem_din, 8'h5A);
    check("rmw0_wre", mem_wre, 1);
    goto(33);
    check("ver0_wre", mem_wre, 0);
    check("ver0_ce", mem_ce, 1);
    goto(49);
    check("drain_busy", busy, 1);
    check("drain_ce", mem_ce, 0);
    check("drain_done", done, 0);
    goto(50);
    check("good_done", done, 1);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_busy", busy, 0);
    goto(52);
    check("good_done_held", done, 1);

    // Stuck-at-0 on bit 0 of address 5
    fault = 1;
    kick(0);
    check("stuck_clear_err", err_count, 0);
    check("stuck_clear_done", done, 0);
    goto(34);
    check("stuck_rmw_err", err_count, 0);
    goto(50);
    check("stuck_done", done, 1);
    check("stuck_err", err_count, 1);
    check("stuck_faddr", fail_addr, 5);
    check("stuck_fgot", fail_got, 8'h54);
    check("stuck_pass", pass, 0);

    // Address bit 3 ignored
    fault = 2;
    kick(0);
    goto(19);
    check("alias_first_err", err_count, 1);
    check("alias_faddr", fail_addr, 0);
    check("alias_fgot", fail_got, 8'hAD);
    goto(50);
    check("alias_err", err_count, 24);
    check("alias_pass", pass, 0);
    check("alias_faddr_final", fail_addr, 0);

    // Reset mid-run (RMW), then a clean rerun
    kick(0);
    goto(20);
    check("mid_err_pre", err_count, 2);
    reset = 1'b1;
    goto(21);
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_ce", mem_ce, 0);
    check("mid_err", err_count, 0);
    check("mid_done", done, 0);
    fault = 0;
    kick(0);
    goto(50);
    check("mid_rerun_done", done, 1);
    check("mid_rerun_pass", pass, 1);

    // Start held high: back-to-back runs
    fault = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    goto(50);
    check("held_done1", done, 1);
    check("held_err1", err_count, 24);
    fault = 0;
    goto(51);
    start = 1'b0;
    check("held_done_drop", done, 0);
    check("held_busy2", busy, 1);
    check("held_err_clear", err_count, 0);
    check("held_din2", mem_din, 8'hA5);
    cyc = 1;
    goto(50);
    check("held_done2", done, 1);
    check("held_pass2", pass, 1);

    // SEED = FF: pattern wraps at address 1
    begin
      logic [7:0] p1;
      p1 = 8'(pattern(32'hFF, 32'd1));
      check("pattern_wrap", p1, 8'h00);
    end
    kick(1);
    check("ff_din0", din_ff, 8'hFF);
    goto(17);
    check("ff_rmw0_din", din_ff, 8'h00);
    goto(18);
    check("ff_rmw1_ad", ad_ff, 1);
    check("ff_rmw1_din", din_ff, 8'hFF);
    goto(50);
    check("ff_done", done_ff, 1);
    check("ff_pass", pass_ff, 1);
    check("ff_err", err_ff, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
